ahb_interconnect: RTL and testbench
===================================

Name: ahb_interconnect

Overview:
- Single-master AHB3-Lite address decoder and response multiplexer between the core data/instruction master and N slaves (RAM, peripherals).
- Broadcasts address-phase signals to all slaves and generates per-slave select, qualified with the bus ready.
- Registers the data-phase owner, muxes the read data, ready, response and read checksum back to the master.
- Contains a built-in default slave that returns a two-cycle ERROR for unmapped transfers.

Parameters:
- SLAVES, 2, number of downstream slaves (1..8).
- SLV_BASE, '{32'h0000_0000, 32'h8000_0000}, per-slave base address; array of SLAVES x 32 bits.
- SLV_MASK, '{32'hFFFF_0000, 32'hFFFF_F000}, per-slave compare mask; array of SLAVES x 32 bits.

Ports:
- s_clk_i  in  1  clock.
- s_resetn_i  in  1  reset; asynchronous, active-low.
- s_haddr_i, s_hwdata_i  in  32 each  master address and write data.
- s_hburst_i  in  3  master burst type.
- s_hsize_i  in  3  master transfer size.
- s_htrans_i  in  2  master transfer type.
- s_hprot_i  in  4  master protection control.
- s_hwrite_i, s_hmastlock_i  in  1 each  master write and lock controls.
- s_hparity_i  in  6  master address-phase parity.
- s_hwchecksum_i  in  7  master write checksum.
- s_hrdata_o  out  32  read data to master.
- s_hrchecksum_o  out  7  read checksum to master.
- s_hready_o, s_hresp_o  out  1 each  ready and response to master.
- m_haddr_o, m_hwdata_o  out  32 each  broadcast address and write data.
- m_hburst_o, m_hsize_o  out  3 each  broadcast burst and size.
- m_htrans_o  out  2  broadcast transfer type.
- m_hprot_o  out  4  broadcast protection control.
- m_hwrite_o, m_hmastlock_o  out  1 each  broadcast write and lock controls.
- m_hparity_o  out  6  broadcast parity.
- m_hwchecksum_o  out  7  broadcast write checksum.
- m_hsel_o  out  SLAVES  per-slave select.
- m_hrdata_i  in  SLAVES x 32  per-slave read data.
- m_hrchecksum_i  in  SLAVES x 7  per-slave read checksum.
- m_hready_i, m_hresp_i  in  SLAVES each  per-slave ready and response.

Behaviour:
- Broadcast: m_h*_o = corresponding s_h*_i, purely combinational.
- Decode: hit[k] = ((s_haddr_i & SLV_MASK[k]) == SLV_BASE[k]).
  - The lowest index wins on overlap.
  - No hit selects the default slave (DS).
- Transfer is defined as s_htrans_i[1] == 1 (NONSEQ or SEQ).
- m_hsel_o[k] = winner[k] & s_hready_o. All selects are 0 while the data phase is stalled, because slaves sample on hsel & transfer without an HREADY input.
- Data-phase register r_dsel: one of {NONE, SLV k, DS}. Updated only on a rising clock edge with s_hready_o = 1:
  - transfer: r_dsel <= decoded target;
  - IDLE or BUSY: r_dsel <= NONE.
- Response mux:
  - NONE: hready = 1, hresp = 0, hrdata = 0, hrchecksum = 0.
  - SLV k: pass through m_*_i[k].
  - DS: driven by the DS FSM.
- DS FSM states:
  - DS_IDLE: transfer accepted to DS -> DS_ERR1.
  - DS_ERR1: hready = 0, hresp = 1; always -> DS_ERR2.
  - DS_ERR2: hready = 1, hresp = 1; new transfer accepted to DS -> DS_ERR1, otherwise -> DS_IDLE.
  - DS read data and checksum are 0.
- Latency: zero added cycles. Combinational address path, one-register data phase.
- Slave stall (selected m_hready_i = 0): r_dsel and the FSM hold; the master sees s_hready_o = 0.
- ERROR from a slave is passed through unchanged, including its two-cycle shape.
- Back-to-back transfers to different slaves: the address phase of B overlaps the data phase of A. The response always comes from the registered r_dsel, never from the current decode.
- Reset (asynchronous, mid-transfer included):
  - r_dsel = NONE, FSM = DS_IDLE;
  - s_hready_o = 1, s_hresp_o = 0, s_hrdata_o = 0, s_hrchecksum_o = 0, m_hsel_o = 0.

Optional Feature:
- Macro: AHB_IC_PARITY_CHECK_EN.
- Defined:
  - compute address-phase parity exactly as the slaves do: bits [3:0] interleaved haddr nibble XOR, [4] XOR of hsize/hburst/hprot/hwrite/hmastlock, [5] XOR of htrans;
  - treat the transfer as present if htrans[1] or (^htrans ^ s_hparity_i[5]);
  - on a parity mismatch with a transfer present, force routing to DS (ERROR), assert no m_hsel_o, and pulse a 1-cycle internal flag.
- Undefined: parity is forwarded untouched, no check, and DS is reached only by unmapped addresses.

Decomposition:
- Package ahb_ic_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants;
  - HRESP_OKAY/ERROR constants;
  - ds_state_t enum {DS_IDLE, DS_ERR1, DS_ERR2};
  - dsel encoding width function clog2(SLAVES+2).
- Sub-module: ahb_default_slave. Contains the DS FSM; inputs are sel and the transfer accepted; outputs are hready and hresp.

Test Plan:
- Read 0x0000_0010 to slave 0 returning 0xDEADBEEF, zero wait -> m_hsel_o = 2'b01 for one cycle; next cycle s_hrdata_o = 0xDEADBEEF, s_hready_o = 1, s_hresp_o = 0.
- Back-to-back writes: 0x0000_0004 (slave 0), then 0x8000_0000 (slave 1) with slave 0 stalling 2 cycles -> m_hsel_o[1] is held low until s_hready_o = 1. The response for the first write comes from slave 0 only.
- Read 0x4000_0000 (unmapped) -> cycle 1: hready = 0, hresp = 1; cycle 2: hready = 1, hresp = 1; then OKAY idle.
- A second unmapped NONSEQ issued during DS_ERR2 -> a second ERR1/ERR2 pair follows with no gap.
- Assert s_resetn_i low during a slave-1 stall -> outputs return to reset values immediately. After release, the first read of slave 0 completes normally.
- With AHB_IC_PARITY_CHECK_EN defined, flip s_hparity_i[0] on a read of 0x0000_0000 -> m_hsel_o = 0 and a two-cycle ERROR results. Without the macro defined -> slave 0 is selected.

Source files
------------

// File: rtl/ahb_ic_pkg.sv
// Shared constants and types for the AHB-Lite single-master interconnect.
package ahb_ic_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE,
      DS_ERR1,
      DS_ERR2
   } ds_state_t;

   // Data-phase owner encoding: 0 = none, 1..SLAVES = slave k-1, SLAVES+1 = default slave
   function automatic int dsel_w(input int slaves);
      return $clog2(slaves + 2);
   endfunction

endpackage

// File: rtl/ahb_interconnect_default_slave.sv
// Default slave: answers every transfer routed to it with a two-cycle ERROR.
module ahb_default_slave
   import ahb_ic_pkg::*;
(
   input  logic s_clk_i,
   input  logic s_resetn_i,
   input  logic sel,
   input  logic ready,
   output logic hready,
   output logic hresp
);

   ds_state_t state, state_nxt;
   logic      accept;

   assign accept = sel & ready;

   // State register
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) state <= DS_IDLE;
      else             state <= state_nxt;
   end

   // Next state: ERR1 always moves on; ERR2 chains straight into a new ERR1 when re-hit
   always_comb begin
      state_nxt = state;
      unique case (state)
         DS_IDLE: if (accept) state_nxt = DS_ERR1;
         DS_ERR1: state_nxt = DS_ERR2;
         DS_ERR2: state_nxt = accept ? DS_ERR1 : DS_IDLE;
         default: state_nxt = DS_IDLE;
      endcase
   end

   // Outputs: stall with ERROR first, then complete with ERROR
   always_comb begin
      hready = 1'b1;
      hresp  = HRESP_OKAY;
      unique case (state)
         DS_ERR1: begin hready = 1'b0; hresp = HRESP_ERROR; end
         DS_ERR2: begin hready = 1'b1; hresp = HRESP_ERROR; end
         default: begin hready = 1'b1; hresp = HRESP_OKAY;  end
      endcase
   end

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB3-Lite decoder and response mux with a built-in default slave.
// Optional: define AHB_IC_PARITY_CHECK_EN to check address-phase parity and
// route mismatching transfers to the default slave.
module ahb_interconnect
   import ahb_ic_pkg::*;
#(
   parameter int          SLAVES           = 2,
   parameter logic [31:0] SLV_BASE [SLAVES] = '{32'h0000_0000, 32'h8000_0000},
   parameter logic [31:0] SLV_MASK [SLAVES] = '{32'hFFFF_0000, 32'hFFFF_F000}
)(
   input  logic                     s_clk_i,
   input  logic                     s_resetn_i,
   input  logic [31:0]              s_haddr_i,
   input  logic [31:0]              s_hwdata_i,
   input  logic [2:0]               s_hburst_i,
   input  logic [2:0]               s_hsize_i,
   input  logic [1:0]               s_htrans_i,
   input  logic [3:0]               s_hprot_i,
   input  logic                     s_hwrite_i,
   input  logic                     s_hmastlock_i,
   input  logic [5:0]               s_hparity_i,
   input  logic [6:0]               s_hwchecksum_i,
   output logic [31:0]              s_hrdata_o,
   output logic [6:0]               s_hrchecksum_o,
   output logic                     s_hready_o,
   output logic                     s_hresp_o,
   output logic [31:0]              m_haddr_o,
   output logic [31:0]              m_hwdata_o,
   output logic [2:0]               m_hburst_o,
   output logic [2:0]               m_hsize_o,
   output logic [1:0]               m_htrans_o,
   output logic [3:0]               m_hprot_o,
   output logic                     m_hwrite_o,
   output logic                     m_hmastlock_o,
   output logic [5:0]               m_hparity_o,
   output logic [6:0]               m_hwchecksum_o,
   output logic [SLAVES-1:0]        m_hsel_o,
   input  logic [SLAVES-1:0][31:0]  m_hrdata_i,
   input  logic [SLAVES-1:0][6:0]   m_hrchecksum_i,
   input  logic [SLAVES-1:0]        m_hready_i,
   input  logic [SLAVES-1:0]        m_hresp_i
);

   localparam int            DW        = dsel_w(SLAVES);
   localparam logic [DW-1:0] DSEL_NONE = '0;
   localparam logic [DW-1:0] DSEL_DS   = DW'(SLAVES + 1);

   logic              xfer;
   logic              par_err;
   logic              found;
   logic [DW-1:0]     tgt;
   logic [DW-1:0]     r_dsel;
   logic [SLAVES-1:0] winner;
   logic              ds_hready;
   logic              ds_hresp;

   // Address-phase signals go to every slave untouched
   assign m_haddr_o      = s_haddr_i;
   assign m_hwdata_o     = s_hwdata_i;
   assign m_hburst_o     = s_hburst_i;
   assign m_hsize_o      = s_hsize_i;
   assign m_htrans_o     = s_htrans_i;
   assign m_hprot_o      = s_hprot_i;
   assign m_hwrite_o     = s_hwrite_i;
   assign m_hmastlock_o  = s_hmastlock_i;
   assign m_hparity_o    = s_hparity_i;
   assign m_hwchecksum_o = s_hwchecksum_i;

`ifdef AHB_IC_PARITY_CHECK_EN
   logic [5:0] par_calc;
   logic       r_par_err;

   // Recompute the parity the slaves will check
   always_comb begin
      par_calc = '0;
      for (int i = 0; i < 8; i++) par_calc[3:0] = par_calc[3:0] ^ s_haddr_i[4*i +: 4];
      par_calc[4] = ^{s_hsize_i, s_hburst_i, s_hprot_i, s_hwrite_i, s_hmastlock_i};
      par_calc[5] = ^s_htrans_i;
   end

   // A corrupted htrans may hide a real transfer, so its parity bit also counts as presence
   assign xfer    = s_htrans_i[1] | (^s_htrans_i ^ s_hparity_i[5]);
   assign par_err = xfer & (par_calc != s_hparity_i);

   // One-cycle pulse for each accepted transfer that failed parity
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) r_par_err <= 1'b0;
      else             r_par_err <= par_err & s_hready_o;
   end
`else
   assign xfer    = s_htrans_i[1];
   assign par_err = 1'b0;
`endif

   // Address decode: lowest index wins, no hit or bad parity goes to the default slave
   always_comb begin
      found  = 1'b0;
      tgt    = DSEL_DS;
      winner = '0;
      for (int k = 0; k < SLAVES; k++) begin
         if (!found && ((s_haddr_i & SLV_MASK[k]) == SLV_BASE[k])) begin
            found     = 1'b1;
            tgt       = DW'(k + 1);
            winner[k] = 1'b1;
         end
      end
      if (par_err) begin
         tgt    = DSEL_DS;
         winner = '0;
      end
   end

   // Slaves have no HREADY input, so selects are suppressed while the data phase stalls
   assign m_hsel_o = winner & {SLAVES{s_hready_o & s_resetn_i}};

   // Data-phase owner, advanced only when the bus moves
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i)     r_dsel <= DSEL_NONE;
      else if (s_hready_o) r_dsel <= xfer ? tgt : DSEL_NONE;
   end

   ahb_default_slave u_ds (
      .s_clk_i    (s_clk_i),
      .s_resetn_i (s_resetn_i),
      .sel        (xfer && (tgt == DSEL_DS)),
      .ready      (s_hready_o),
      .hready     (ds_hready),
      .hresp      (ds_hresp)
   );

   // Response mux keyed on the registered owner, never on the live decode
   always_comb begin
      s_hready_o     = 1'b1;
      s_hresp_o      = HRESP_OKAY;
      s_hrdata_o     = '0;
      s_hrchecksum_o = '0;
      if (r_dsel == DSEL_DS) begin
         s_hready_o = ds_hready;
         s_hresp_o  = ds_hresp;
      end else begin
         for (int k = 0; k < SLAVES; k++) begin
            if (r_dsel == DW'(k + 1)) begin
               s_hready_o     = m_hready_i[k];
               s_hresp_o      = m_hresp_i[k];
               s_hrdata_o     = m_hrdata_i[k];
               s_hrchecksum_o = m_hrchecksum_i[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_interconnect.sv
// Scoreboard bench for ahb_interconnect with two behavioural wait-state slaves.
module tb_ahb_interconnect;

   logic              clk, rst_n;
   logic [31:0]       haddr, hwdata;
   logic [2:0]        hburst, hsize;
   logic [1:0]        htrans;
   logic [3:0]        hprot;
   logic              hwrite, hlock;
   logic [5:0]        hpar;
   logic [6:0]        hwcs;
   logic [31:0]       s_hrdata;
   logic [6:0]        s_hrcs;
   logic              s_hready, s_hresp;
   logic [31:0]       m_haddr, m_hwdata;
   logic [2:0]        m_hburst, m_hsize;
   logic [1:0]        m_htrans;
   logic [3:0]        m_hprot;
   logic              m_hwrite, m_hlock;
   logic [5:0]        m_hpar;
   logic [6:0]        m_hwcs;
   logic [1:0]        m_hsel;
   logic [1:0][31:0]  m_hrdata;
   logic [1:0][6:0]   m_hrcs;
   logic [1:0]        m_hready, m_hresp;

   ahb_interconnect dut (
      .s_clk_i(clk), .s_resetn_i(rst_n),
      .s_haddr_i(haddr), .s_hwdata_i(hwdata), .s_hburst_i(hburst), .s_hsize_i(hsize),
      .s_htrans_i(htrans), .s_hprot_i(hprot), .s_hwrite_i(hwrite), .s_hmastlock_i(hlock),
      .s_hparity_i(hpar), .s_hwchecksum_i(hwcs),
      .s_hrdata_o(s_hrdata), .s_hrchecksum_o(s_hrcs), .s_hready_o(s_hready), .s_hresp_o(s_hresp),
      .m_haddr_o(m_haddr), .m_hwdata_o(m_hwdata), .m_hburst_o(m_hburst), .m_hsize_o(m_hsize),
      .m_htrans_o(m_htrans), .m_hprot_o(m_hprot), .m_hwrite_o(m_hwrite), .m_hmastlock_o(m_hlock),
      .m_hparity_o(m_hpar), .m_hwchecksum_o(m_hwcs), .m_hsel_o(m_hsel),
      .m_hrdata_i(m_hrdata), .m_hrchecksum_i(m_hrcs), .m_hready_i(m_hready), .m_hresp_i(m_hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- slave models ----------------
   logic [31:0] rd_cfg [2];
   logic [6:0]  cs_cfg [2];
   int          wcfg   [2];
   logic        act    [2];
   int          cnt    [2];

   initial begin
      rd_cfg[0] = 32'hDEAD_BEEF; cs_cfg[0] = 7'h5B;
      rd_cfg[1] = 32'h1234_5678; cs_cfg[1] = 7'h26;
      wcfg[0] = 0; wcfg[1] = 0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin act[k] <= 1'b0; cnt[k] <= 0; end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_hsel[k] && m_htrans[1]) begin act[k] <= 1'b1; cnt[k] <= wcfg[k]; end
            else if (act[k] && cnt[k] == 0) act[k] <= 1'b0;
            else if (act[k]) cnt[k] <= cnt[k] - 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         m_hready[k] = !act[k] || (cnt[k] == 0);
         m_hresp[k]  = 1'b0;
         m_hrdata[k] = rd_cfg[k];
         m_hrcs[k]   = cs_cfg[k];
      end
   end

   // ---------------- reference helpers ----------------
   function automatic int tgt_of(input logic [31:0] a);
      if (a[31:16] == 16'h0000)  return 0;
      if (a[31:12] == 20'h80000) return 1;
      return 2;
   endfunction

   function automatic logic [5:0] par_of(input logic [31:0] a, input logic [2:0] sz,
                                         input logic [2:0] bu, input logic [3:0] pr,
                                         input logic w, input logic l, input logic [1:0] tr);
      logic [5:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) p[i % 4] = p[i % 4] ^ a[i];
      p[4] = ^{sz, bu, pr, w, l};
      p[5] = tr[0] ^ tr[1];
      return p;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] d;
      logic [6:0]  cs;
      logic        resp;
      logic        ds;
   } exp_t;

   exp_t sb[$];
   bit   dp_pend = 0;
   int   stalls  = 0;

   // Data-phase monitor: sampled on the falling edge, between driver updates
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete(); dp_pend = 0; stalls = 0;
         end else begin
            if (dp_pend) begin
               if (sb.size() == 0) begin
                  chk("sb_empty", 1, 0);
               end else if (!s_hready) begin
                  stalls++;
                  if (sb[0].ds) chk("ds_err1_resp", s_hresp, 1);
               end else begin
                  e = sb.pop_front();
                  chk("rdata", s_hrdata, e.d);
                  chk("rcsum", s_hrcs, e.cs);
                  chk("hresp", s_hresp, e.resp);
                  if (e.ds) chk("ds_stalls", stalls, 1);
                  stalls = 0;
               end
            end
            if (s_hready) dp_pend = htrans[1];
         end
      end
   end

   task automatic drive_idle();
      htrans = 2'b00;
      hpar   = par_of(haddr, hsize, hburst, hprot, hwrite, hlock, 2'b00);
   endtask

   // Issue one NONSEQ and hold it until accepted; returns at posedge+1 after acceptance
   task automatic xfer(input logic [31:0] a, input logic w, input logic flip);
      int         t;
      logic [1:0] oh;
      exp_t       e;
      bit         first;
      haddr  = a;      hwrite = w;      hwdata = a ^ 32'h5A5A_0000;
      hburst = 3'b000; hsize  = 3'b010; hprot  = 4'b0011; hlock = 1'b0;
      htrans = 2'b10;  hwcs   = a[6:0];
      hpar   = par_of(a, hsize, hburst, hprot, w, hlock, htrans);
      if (flip) hpar[0] = ~hpar[0];
      t = tgt_of(a);
`ifdef AHB_IC_PARITY_CHECK_EN
      if (flip) t = 2;
`endif
      oh = '0;
      if (t < 2) oh[t] = 1'b1;
      e.d    = (t < 2) ? rd_cfg[t] : 32'h0;
      e.cs   = (t < 2) ? cs_cfg[t] : 7'h0;
      e.resp = (t == 2);
      e.ds   = (t == 2);
      sb.push_back(e);
      first = 1;
      for (int n = 0; n <= 30; n++) begin
         if (n == 30) begin chk("xfer_timeout", 1, 0); break; end
         @(negedge clk);
         if (first) begin
            chk("bc_addr", m_haddr, a);
            chk("bc_ctl", {m_hwdata, m_hburst, m_hsize, m_htrans, m_hprot, m_hwrite, m_hlock, m_hpar, m_hwcs},
                          {hwdata, hburst, hsize, htrans, hprot, hwrite, hlock, hpar, hwcs});
            first = 0;
         end
         chk("hsel", m_hsel, s_hready ? oh : 2'b00);
         if (s_hready) break;
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      chk({tag, "_rdy"},  s_hready, 1);
      chk({tag, "_resp"}, s_hresp,  0);
      chk({tag, "_data"}, {s_hrcs, s_hrdata}, 39'h0);
      @(posedge clk); #1;
   endtask

   logic [31:0] bnd [4];

   initial begin
      #200000;
      $display("FAIL watchdog got=0 exp=1");
      $fatal(1, "watchdog");
   end

   initial begin
      bnd[0] = 32'h0000_FFFC; bnd[1] = 32'h0001_0000;
      bnd[2] = 32'h8000_0FFC; bnd[3] = 32'h8000_1000;
      rst_n = 1'b0;
      haddr = 32'h0; hwdata = 32'h0; hburst = 3'b0; hsize = 3'b010; hprot = 4'b0011;
      hwrite = 1'b0; hlock = 1'b0; hwcs = 7'h0;
      drive_idle();
      #23;
      chk("rst_rdy",  s_hready, 1);
      chk("rst_resp", s_hresp,  0);
      chk("rst_data", {s_hrcs, s_hrdata}, 39'h0);
      chk("rst_hsel", m_hsel, 2'b00);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero-wait read from slave 0
      xfer(32'h0000_0010, 1'b0, 1'b0);
      drain();
      idle_chk("idle0");

      // Back-to-back writes, slave 0 stalls two cycles
      wcfg[0] = 2;
      xfer(32'h0000_0004, 1'b1, 1'b0);
      xfer(32'h8000_0000, 1'b1, 1'b0);
      drain();
      wcfg[0] = 0;

      // Unmapped read, then OKAY idle
      xfer(32'h4000_0000, 1'b0, 1'b0);
      drain();
      idle_chk("idle_ds");

      // Second unmapped transfer lands in ERR2 and chains directly
      xfer(32'h4000_0000, 1'b0, 1'b0);
      xfer(32'h4000_0004, 1'b0, 1'b0);
      drain();

      // Mask boundaries, back to back
      for (int i = 0; i < 4; i++) xfer(bnd[i], i[0], 1'b0);
      drain();
      idle_chk("idle_bnd");

      // Asynchronous reset in the middle of a slave 1 stall
      wcfg[1] = 6;
      xfer(32'h8000_0000, 1'b0, 1'b0);
      @(posedge clk); #3;
      chk("pre_rst_stall", s_hready, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_rdy",  s_hready, 1);
      chk("arst_resp", s_hresp,  0);
      chk("arst_data", {s_hrcs, s_hrdata}, 39'h0);
      chk("arst_hsel", m_hsel, 2'b00);
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
      wcfg[1] = 0;
      @(posedge clk); #1;
      xfer(32'h0000_0000, 1'b0, 1'b0);
      drain();

      // Corrupted address parity on a slave 0 read
      xfer(32'h0000_0000, 1'b0, 1'b1);
      drain();
      idle_chk("idle_end");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
